// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, PC increment and trap vectors.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [31:0] ILLOP  = 32'h8000_0004;
    localparam logic [31:0] XADR   = 32'h8000_0008;

    // Bit 31 is the kernel bit: it is carried through untouched and never receives a carry.
    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return {p[31], p[30:0] + PC_INC[30:0]};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: PC register loop, redirect, instruction memory and decode handshakes.
interface inst_fetch_if;
    logic [31:0] pc;
    logic [31:0] pc_in;
    logic        pc_wr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc_plus4;

    modport master (
        input  pc, redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        output pc_in, pc_wr, imem_req, imem_addr, id_valid, id_inst, id_pc_plus4
    );

    modport slave (
        output pc, redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  pc_in, pc_wr, imem_req, imem_addr, id_valid, id_inst, id_pc_plus4
    );
endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {inst, pc_plus4} between fetch and decode; flush beats push and pop.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              valid_o,
    output logic              full_o
);

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [2];
    logic              do_push, do_pop;

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'(DEPTH));
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & valid_o & ~flush_i;
    // Head reads as zero when empty so decode never sees stale storage.
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            if (do_push && !do_pop)      count_d = count_q + 2'd1;
            else if (do_pop && !do_push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer: closes the PC loop, drives imem req/ack, fills the decode buffer.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    inst_fetch_if.master  bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  pc_plus4;
    logic         buf_full, buf_valid;
    logic         req, complete;
    logic [63:0]  buf_rdata;

    assign pc_plus4 = pc_inc(bus.pc);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req       = 1'b0;
        bus.imem_addr = bus.pc;
        case (state_q)
            S_IDLE: begin
                req = ~buf_full & ~bus.redirect_valid;
                if (req && !bus.imem_ack) begin
                    state_d = S_BUSY;
                    addr_d  = bus.pc;
                end
            end
            S_BUSY: begin
                req           = 1'b1;
                bus.imem_addr = addr_q;
                if (bus.imem_ack)            state_d = S_IDLE;
                else if (bus.redirect_valid) state_d = S_DROP;
            end
            S_DROP: begin
                req           = 1'b1;
                bus.imem_addr = addr_q;
                if (bus.imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A drained ack in S_DROP belongs to a flushed fetch and never completes.
    assign complete = bus.imem_ack & req & ~bus.redirect_valid & (state_q != S_DROP);

    assign bus.imem_req = reset & req;
    assign bus.pc_wr    = reset & (bus.redirect_valid | complete);
    assign bus.pc_in    = bus.redirect_valid ? bus.redirect_pc : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    fetch_buf #(
        .DATA_W (64),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (complete),
        .pop_i   (bus.id_ready),
        .flush_i (bus.redirect_valid),
        .wdata_i ({bus.imem_rdata, pc_plus4}),
        .rdata_o (buf_rdata),
        .valid_o (buf_valid),
        .full_o  (buf_full)
    );

    assign bus.id_valid    = buf_valid;
    assign bus.id_inst     = buf_rdata[63:32];
    assign bus.id_pc_plus4 = buf_rdata[31:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: PC register and memory models plus a decode-side scoreboard.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rst_pc = 32'd0;
    int          lat = 0;
    logic        mem_hold = 1'b0;
    int          wc;
    int          passed = 0;
    int          total = 0;
    logic [63:0] sbq [$];
    logic        drop_pend = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.BUF_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] plus4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    // PC register closing the loop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           bus.pc <= rst_pc;
        else if (bus.pc_wr)   bus.pc <= bus.pc_in;
    end

    // Memory: acks after `lat` extra request cycles unless held off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          wc <= 0;
        else if (bus.imem_req && bus.imem_ack) wc <= 0;
        else if (bus.imem_req)               wc <= wc + 1;
    end
    assign bus.imem_ack   = reset & bus.imem_req & ~mem_hold & (wc >= lat);
    assign bus.imem_rdata = bus.imem_ack ? memf(bus.imem_addr) : 32'd0;

    // Scoreboard: expected entries pushed on accepted fetches, checked on decode pops
    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
            drop_pend = 1'b0;
        end else if (bus.redirect_valid) begin
            sbq.delete();
            if (bus.imem_req && !bus.imem_ack) drop_pend = 1'b1;
            else if (bus.imem_ack)             drop_pend = 1'b0;
        end else begin
            if (bus.id_valid && bus.id_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    $display("FAIL sb_pop: got %h/%h want (empty queue)", bus.id_inst, bus.id_pc_plus4);
                end else if ({bus.id_inst, bus.id_pc_plus4} !== sbq[0]) begin
                    $display("FAIL sb_pop: got %h/%h want %h/%h", bus.id_inst, bus.id_pc_plus4,
                             sbq[0][63:32], sbq[0][31:0]);
                    void'(sbq.pop_front());
                end else begin
                    passed++;
                    void'(sbq.pop_front());
                end
            end
            if (bus.imem_req && bus.imem_ack) begin
                if (drop_pend) drop_pend = 1'b0;
                else sbq.push_back({memf(bus.imem_addr), plus4(bus.imem_addr)});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] p);
        reset = 1'b0;
        rst_pc = p;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.id_ready = 1'b0;
        mem_hold = 1'b0;
        lat = 0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.id_ready = 1'b1;
        cyc();
        total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.imem_req); else passed++;
        total++; if (bus.pc_wr !== 1'b0) $display("FAIL rst_pc_wr: got %b want 0", bus.pc_wr); else passed++;
        total++; if (bus.id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b want 0", bus.id_valid); else passed++;
        total++; if (bus.id_inst !== 32'd0) $display("FAIL rst_id_inst: got %h want 0", bus.id_inst); else passed++;
        total++; if (bus.id_pc_plus4 !== 32'd0) $display("FAIL rst_id_pc4: got %h want 0", bus.id_pc_plus4); else passed++;
    endtask

    task automatic test_stream();
        do_reset(32'd0);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (bus.imem_addr !== 32'(4*i)) $display("FAIL stream_addr%0d: got %h want %h", i, bus.imem_addr, 32'(4*i)); else passed++;
            total++; if (bus.pc_wr !== 1'b1 || bus.pc_in !== 32'(4*i+4))
                $display("FAIL stream_pc%0d: got wr=%b in=%h want wr=1 in=%h", i, bus.pc_wr, bus.pc_in, 32'(4*i+4)); else passed++;
            if (i > 0) begin
                total++; if (bus.id_valid !== 1'b1 || bus.id_pc_plus4 !== 32'(4*i))
                    $display("FAIL stream_head%0d: got v=%b pc4=%h want v=1 pc4=%h", i, bus.id_valid, bus.id_pc_plus4, 32'(4*i)); else passed++;
            end
            cyc();
        end
    endtask

    task automatic test_slow_mem();
        do_reset(32'h10);
        lat = 2;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10)
                $display("FAIL slow_addr%0d: got req=%b addr=%h want req=1 addr=00000010", i, bus.imem_req, bus.imem_addr); else passed++;
            total++; if (bus.pc_wr !== (i == 2)) $display("FAIL slow_pc_wr%0d: got %b want %b", i, bus.pc_wr, (i == 2)); else passed++;
            cyc();
        end
        #1;
        total++; if (bus.id_valid !== 1'b1 || bus.id_inst !== (32'h10 ^ 32'hDEAD_BEEF) || bus.id_pc_plus4 !== 32'h14)
            $display("FAIL slow_head: got v=%b inst=%h pc4=%h want v=1 inst=%h pc4=00000014",
                     bus.id_valid, bus.id_inst, bus.id_pc_plus4, 32'h10 ^ 32'hDEAD_BEEF); else passed++;
        total++; if (bus.imem_addr !== 32'h14) $display("FAIL slow_next: got %h want 00000014", bus.imem_addr); else passed++;
    endtask

    task automatic test_back_pressure();
        do_reset(32'd0);
        cyc();
        cyc();
        #1;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_full_req: got %b want 0", bus.imem_req); else passed++;
        total++; if (bus.pc !== 32'd8) $display("FAIL bp_pc: got %h want 00000008", bus.pc); else passed++;
        total++; if (bus.id_pc_plus4 !== 32'd4) $display("FAIL bp_head: got %h want 00000004", bus.id_pc_plus4); else passed++;
        cyc();
        bus.id_ready = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_pop_req: got %b want 0", bus.imem_req); else passed++;
        cyc();
        bus.id_ready = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd8)
            $display("FAIL bp_next: got req=%b addr=%h want req=1 addr=00000008", bus.imem_req, bus.imem_addr); else passed++;
        total++; if (bus.id_pc_plus4 !== 32'd8) $display("FAIL bp_head2: got %h want 00000008", bus.id_pc_plus4); else passed++;
        cyc();
        #1;
        total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_refull: got %b want 0", bus.imem_req); else passed++;
    endtask

    task automatic test_redirect_busy();
        do_reset(32'h20);
        mem_hold = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20 || bus.pc_wr !== 1'b0)
            $display("FAIL rb_req: got req=%b addr=%h wr=%b want 1/00000020/0", bus.imem_req, bus.imem_addr, bus.pc_wr); else passed++;
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = ILLOP;
        #1;
        total++; if (bus.pc_wr !== 1'b1 || bus.pc_in !== 32'h8000_0004)
            $display("FAIL rb_pc: got wr=%b in=%h want 1/80000004", bus.pc_wr, bus.pc_in); else passed++;
        cyc();
        bus.redirect_valid = 1'b0;
        mem_hold = 1'b0;
        #1;
        total++; if (bus.pc !== 32'h8000_0004) $display("FAIL rb_pcreg: got %h want 80000004", bus.pc); else passed++;
        total++; if (bus.imem_addr !== 32'h20 || bus.imem_ack !== 1'b1 || bus.pc_wr !== 1'b0)
            $display("FAIL rb_drain: got addr=%h ack=%b wr=%b want 00000020/1/0", bus.imem_addr, bus.imem_ack, bus.pc_wr); else passed++;
        cyc();
        #1;
        total++; if (bus.id_valid !== 1'b0) $display("FAIL rb_empty: got %b want 0", bus.id_valid); else passed++;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8000_0004)
            $display("FAIL rb_target: got req=%b addr=%h want 1/80000004", bus.imem_req, bus.imem_addr); else passed++;
        cyc();
        #1;
        total++; if (bus.id_inst !== (32'h8000_0004 ^ 32'hDEAD_BEEF) || bus.id_pc_plus4 !== 32'h8000_0008)
            $display("FAIL rb_head: got %h/%h want %h/80000008", bus.id_inst, bus.id_pc_plus4, 32'h8000_0004 ^ 32'hDEAD_BEEF); else passed++;
    endtask

    task automatic test_redirect_ack_pop();
        // Full buffer, decode popping, redirect
        do_reset(32'd0);
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = XADR;
        bus.id_ready = 1'b1;
        #1;
        total++; if (bus.pc_wr !== 1'b1 || bus.pc_in !== 32'h8000_0008 || bus.imem_req !== 1'b0)
            $display("FAIL rf_pc: got wr=%b in=%h req=%b want 1/80000008/0", bus.pc_wr, bus.pc_in, bus.imem_req); else passed++;
        cyc();
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b0;
        #1;
        total++; if (bus.id_valid !== 1'b0) $display("FAIL rf_flush: got %b want 0", bus.id_valid); else passed++;
        total++; if (bus.imem_addr !== 32'h8000_0008) $display("FAIL rf_target: got %h want 80000008", bus.imem_addr); else passed++;
        // Redirect landing on the ack cycle of a slow fetch while popping
        do_reset(32'd0);
        lat = 1;
        cyc();
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = XADR;
        bus.id_ready = 1'b1;
        #1;
        total++; if (bus.imem_ack !== 1'b1 || bus.pc_wr !== 1'b1 || bus.pc_in !== 32'h8000_0008)
            $display("FAIL ra_pc: got ack=%b wr=%b in=%h want 1/1/80000008", bus.imem_ack, bus.pc_wr, bus.pc_in); else passed++;
        cyc();
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b0;
        #1;
        total++; if (bus.id_valid !== 1'b0) $display("FAIL ra_flush: got %b want 0", bus.id_valid); else passed++;
        total++; if (bus.imem_addr !== 32'h8000_0008 || bus.pc !== 32'h8000_0008)
            $display("FAIL ra_target: got addr=%h pc=%h want 80000008", bus.imem_addr, bus.pc); else passed++;
        // Reset asserted while a request is outstanding
        do_reset(32'd0);
        cyc();
        mem_hold = 1'b1;
        cyc();
        #1;
        total++; if (bus.id_valid !== 1'b1 || bus.imem_req !== 1'b1)
            $display("FAIL rm_pre: got v=%b req=%b want 1/1", bus.id_valid, bus.imem_req); else passed++;
        reset = 1'b0;
        #1;
        total++; if (bus.imem_req !== 1'b0 || bus.pc_wr !== 1'b0 || bus.id_valid !== 1'b0 ||
                     bus.id_inst !== 32'd0 || bus.id_pc_plus4 !== 32'd0)
            $display("FAIL rm_outs: got req=%b wr=%b v=%b inst=%h pc4=%h want all 0",
                     bus.imem_req, bus.pc_wr, bus.id_valid, bus.id_inst, bus.id_pc_plus4); else passed++;
    endtask

    task automatic test_kernel_bit();
        do_reset(32'hFFFF_FFFC);
        bus.id_ready = 1'b1;
        #1;
        total++; if (bus.pc_in !== 32'h8000_0000) $display("FAIL kb_hi: got %h want 80000000", bus.pc_in); else passed++;
        cyc();
        #1;
        total++; if (bus.imem_addr !== 32'h8000_0000) $display("FAIL kb_hi_addr: got %h want 80000000", bus.imem_addr); else passed++;
        do_reset(32'h7FFF_FFFC);
        bus.id_ready = 1'b1;
        #1;
        total++; if (bus.pc_in !== 32'h0000_0000) $display("FAIL kb_lo: got %h want 00000000", bus.pc_in); else passed++;
        cyc();
        #1;
        total++; if (bus.id_pc_plus4 !== 32'h0000_0000 || bus.id_valid !== 1'b1)
            $display("FAIL kb_lo_head: got v=%b pc4=%h want 1/00000000", bus.id_valid, bus.id_pc_plus4); else passed++;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.id_ready = 1'b0;
        test_reset();
        test_stream();
        test_slow_mem();
        test_back_pressure();
        test_redirect_busy();
        test_redirect_ack_pop();
        test_kernel_bit();
        reset = 1'b0;
        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch sequencer that sits directly downstream of the PC register and closes its loop. Each cycle it drives the next-PC value and write enable back to the PC register, issues a request to instruction memory, and receives the instruction over a req/ack handshake. Fetched instructions go into a 2-entry buffer that feeds the decode stage over a valid/ready handshake. A redirect input (branch/jump/exception vector) overrides sequential fetch and flushes in-flight work.

## Interface
- `BUF_DEPTH`, 2: decode buffer entries; only 2 is supported.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc` in 32: current PC from the PC register.
- `pc_in` out 32: next PC to the PC register.
- `pc_wr` out 1: PC register write enable.
- `redirect_valid` in 1: one-cycle redirect pulse.
- `redirect_pc` in 32: redirect target, e.g. 0x80000004 ILLOP or 0x80000008 XADR.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: request completed this cycle.
- `imem_rdata` in 32: instruction; valid only when `imem_ack`=1.
- `id_valid` out 1: buffer head is valid.
- `id_ready` in 1: decode accepts the head.
- `id_inst` out 32: head instruction.
- `id_pc_plus4` out 32: head PC+4.

## Operation
- Sequential increment: `pc_plus4` = {pc[31], pc[30:0]+4}. Bit 31 is the kernel/supervisor bit and never carries or changes.
- Room condition: `room` = buffer count < 2, using the current-cycle count. A same-cycle pop does not free a slot for a push.
- **S_IDLE**
  - `imem_req` = room & ~redirect_valid; `imem_addr` = pc.
  - Request with ack in the same cycle: completion, stay in S_IDLE.
  - Request without ack: `addr_q`<=pc, go to S_BUSY.
- **S_BUSY**
  - `imem_req`=1; `imem_addr`=addr_q, held stable until ack.
  - Ack: completion, go to S_IDLE.
- **S_DROP**
  - `imem_req`=1; `imem_addr`=addr_q.
  - Ack: rdata discarded, go to S_IDLE.
- **Completion** (ack with no redirect in the same cycle)
  - Push {imem_rdata, pc_plus4} into the buffer.
  - `pc_wr`=1, `pc_in`=pc_plus4.
- **Redirect** (`redirect_valid`=1), which beats every other event in the same cycle:
  - `pc_wr`=1, `pc_in`=redirect_pc.
  - Buffer is flushed: count and pointers go to 0, and no push or pop takes effect.
  - Any ack in that cycle is discarded.
  - S_BUSY without ack → S_DROP; S_BUSY with ack → S_IDLE.
  - In S_DROP: without ack, stay in S_DROP; with ack, go to S_IDLE.
  - In S_IDLE: no request that cycle, stay in S_IDLE.
- **Otherwise**: `pc_wr`=0; `pc_in`=pc_plus4 (don't-care).
- **Buffer**: 2-entry FIFO.
  - `id_valid` = count≠0; pop on id_valid & id_ready.
  - Push and pop in the same cycle leaves count unchanged.
- **Ack outside a request**: `imem_ack` while `imem_req`=0 is a protocol error and is ignored.

## Timing
- Reset values (`reset`=0, asynchronous): state S_IDLE, count 0, pointers 0, addr_q 0.
- Outputs while `reset`=0: `imem_req`=0, `pc_wr`=0, `id_valid`=0, `id_inst`=0, `id_pc_plus4`=0.
- Reset asserted mid-operation drops any outstanding request and does not wait for its ack. The memory model must also be reset.
- Latency: ack in cycle N → `id_valid`=1 in cycle N+1. The PC register updates at edge N.
- Throughput: with zero-wait memory (ack in the request cycle), one instruction per cycle, provided decode keeps the buffer below full.
- Redirect in cycle N: PC holds redirect_pc after edge N. The first request to the target is issued in cycle N+1 from S_IDLE, or after the drain ack from S_DROP.

## Structure
- Shared `cpu_pkg` holds:
  - fetch state enum (S_IDLE, S_BUSY, S_DROP);
  - `PC_INC`=4;
  - `ILLOP`=0x80000004, `XADR`=0x80000008.
- One sub-module, `fetch_buf`: 2-entry FIFO of {inst, pc_plus4}, with push, pop, and a synchronous flush that has priority over both.
- The FSM, next-PC mux and request logic live in `inst_fetch`.

## Test plan
- **Zero-wait streaming**: release reset with pc=0, ack every request, id_ready=1 → imem_addr 0,4,8 on consecutive cycles; id_pc_plus4 4,8,12; pc_wr=1 each cycle.
- **Slow memory**: ack 3 cycles after the request at pc=0x10 → imem_addr held at 0x10 for 3 cycles, pc_wr=1 only in the ack cycle, id_inst visible the next cycle.
- **Back-pressure**: id_ready=0 from reset → two fetches (0, 4), count=2, imem_req=0, pc stays 8; id_ready=1 for one cycle → one pop, and the next request is at 8.
- **Redirect during S_BUSY**: redirect to 0x80000004 while waiting on 0x20 → buffer empty, S_DROP, ack data not pushed, next imem_addr=0x80000004.
- **Redirect with simultaneous ack and full-buffer pop**:
  - pc_in=redirect_pc, rdata discarded, id_valid=0 next cycle.
  - Also assert reset mid-S_BUSY → all outputs at their reset values immediately.
- **Kernel bit**: pc=0xFFFFFFFC → pc_in=0x80000000; pc=0x7FFFFFFC → pc_in=0x00000000.
